// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: scans a snapshot of per-digit segment patterns onto
// a common-anode display with a per-slot blank window and PWM dimming.
module seven_segment_scanner #(
  parameter int DISPLAY_WIDTH = 8,
  parameter int REFRESH_DIV   = 1024,
  parameter int BLANK_CYCLES  = 16,
  parameter int BRIGHT_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DISPLAY_WIDTH-1:0][6:0] seven_segment_array,
  input  logic                          enable,
  input  logic [BRIGHT_WIDTH-1:0]       brightness,
  output logic [DISPLAY_WIDTH-1:0]      anode,
  output logic [6:0]                    cathode,
  output logic                          frame_sync
);

  localparam int DW = (DISPLAY_WIDTH > 1) ? $clog2(DISPLAY_WIDTH) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int OW = CW + BRIGHT_WIDTH + 1;

  localparam logic [DW-1:0] D_LAST = DW'(DISPLAY_WIDTH - 1);
  localparam logic [CW-1:0] C_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [OW-1:0] ACTIVE = OW'(REFRESH_DIV - BLANK_CYCLES);
  localparam logic [OW-1:0] BLANK  = OW'(BLANK_CYCLES);

  logic [DW-1:0]                 d_q, d_d;
  logic [CW-1:0]                 c_q, c_d;
  logic [DISPLAY_WIDTH-1:0][6:0] snap_q;
  logic [BRIGHT_WIDTH-1:0]       snap_bright_q;

  logic                     frame_start;
  logic                     c_wrap;
  logic                     d_wrap;
  logic                     lit;
  logic [OW-1:0]            c_ext;
  logic [OW-1:0]            on_len;
  logic [DISPLAY_WIDTH-1:0] anode_d;
  logic [6:0]               cathode_d;

  assign frame_start = enable && (d_q == '0) && (c_q == '0);
  assign c_wrap      = (c_q == C_LAST);
  assign d_wrap      = (d_q == D_LAST);
  assign c_ext       = OW'(c_q);

  // Product kept at full width so the shift sees every bit.
  assign on_len = (ACTIVE * (OW'(snap_bright_q) + OW'(1)))
                  >> BRIGHT_WIDTH;

  assign lit = enable
            && (c_ext >= BLANK)
            && ((c_ext - BLANK) < on_len);

  always_comb begin
    d_d = d_q;
    c_d = c_q;
    unique case (1'b1)
      !enable: begin
        d_d = '0;
        c_d = '0;
      end
      enable && !c_wrap: begin
        c_d = c_q + CW'(1);
      end
      enable && c_wrap && !d_wrap: begin
        c_d = '0;
        d_d = d_q + DW'(1);
      end
      enable && c_wrap && d_wrap: begin
        c_d = '0;
        d_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    anode_d   = '1;
    cathode_d = 7'h7F;
    if (lit) begin
      anode_d[d_q] = 1'b0;
      cathode_d    = ~snap_q[d_q];
    end
  end

  // (0,0) is always blank, so loading the snapshot on its edge is safe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q           <= '0;
      c_q           <= '0;
      snap_q        <= '0;
      snap_bright_q <= '0;
      anode         <= '1;
      cathode       <= 7'h7F;
      frame_sync    <= 1'b0;
    end else begin
      d_q        <= d_d;
      c_q        <= c_d;
      anode      <= anode_d;
      cathode    <= cathode_d;
      frame_sync <= frame_start;
      if (frame_start) begin
        snap_q        <= seven_segment_array;
        snap_bright_q <= brightness;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed and random stimulus checked every cycle
// against a frame-position model, plus literal spot checks.
module tb_seven_segment_scanner;

  localparam int DW = 8;
  localparam int RD = 32;
  localparam int BC = 4;
  localparam int BW = 2;
  localparam int FRAME = RD * DW;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic [DW-1:0][6:0] arr = '0;
  logic [BW-1:0]      bright = '0;
  logic [DW-1:0]      anode;
  logic [6:0]         cathode;
  logic               frame_sync;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DISPLAY_WIDTH(DW),
    .REFRESH_DIV(RD),
    .BLANK_CYCLES(BC),
    .BRIGHT_WIDTH(BW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seven_segment_array(arr),
    .enable(enable),
    .brightness(bright),
    .anode(anode),
    .cathode(cathode),
    .frame_sync(frame_sync)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  // Model: k counts enabled cycles since the last restart at (0,0).
  int                 k = 0;
  logic [DW-1:0][6:0] m_snap = '0;
  int                 m_b = 0;
  int                 m_dig;
  int                 m_c;
  int                 m_on;
  logic [DW-1:0]      e_anode = '1;
  logic [6:0]         e_cath = 7'h7F;
  logic               e_fs = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k = 0;
      m_snap = '0;
      m_b = 0;
      e_anode = '1;
      e_cath = 7'h7F;
      e_fs = 1'b0;
    end else if (!enable) begin
      k = 0;
      e_anode = '1;
      e_cath = 7'h7F;
      e_fs = 1'b0;
    end else begin
      m_dig = (k / RD) % DW;
      m_c = k % RD;
      e_fs = (k % FRAME) == 0;
      if (e_fs) begin
        m_snap = arr;
        m_b = int'(bright);
      end
      m_on = ((RD - BC) * (m_b + 1)) / (1 << BW);
      e_anode = '1;
      e_cath = 7'h7F;
      if (m_c >= BC && (m_c - BC) < m_on) begin
        e_anode[m_dig] = 1'b0;
        e_cath = ~m_snap[m_dig];
      end
      k++;
    end
  end

  bit cmp_on = 0;
  int last_dig = -1;
  int blank_run = 0;
  int cur;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("anode", 32'(anode), 32'(e_anode));
      chk("cathode", 32'(cathode), 32'(e_cath));
      chk("frame_sync", 32'(frame_sync), 32'(e_fs));
      chk("onehot", 32'($countones(~anode) <= 1), 32'(1));
      if (anode === '1) begin
        blank_run++;
      end else begin
        cur = 0;
        for (int i = 0; i < DW; i++)
          if (!anode[i]) cur = i;
        if (last_dig >= 0 && cur != last_dig)
          chk("gap", 32'(blank_run >= BC), 32'(1));
        last_dig = cur;
        blank_run = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_sync !== 1'b1 && n < 600);
    chk("fs_wait", 32'(frame_sync === 1'b1), 32'(1));
  endtask

  task automatic wait_anode(input logic [DW-1:0] v, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (anode !== v && n < 600);
    chk(nm, 32'(anode), 32'(v));
  endtask

  int lit_cnt[DW];

  // Starts on the frame_sync sample and covers one whole frame.
  task automatic scan_frame();
    logic [DW-1:0] sel;
    for (int s = 0; s < DW; s++) lit_cnt[s] = 0;
    for (int n = 0; n < FRAME; n++) begin
      if (n > 0) @(negedge clk);
      for (int s = 0; s < DW; s++) begin
        sel = '1;
        sel[s] = 1'b0;
        if (anode === sel) lit_cnt[s]++;
      end
    end
  endtask

  int n;

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      arr = {2{28'($urandom)}};
      bright = 2'($urandom);
      enable = 1'($urandom);
      @(negedge clk);
      cmp_on = 1;
      chk("rst_anode", 32'(anode), 32'hFF);
      chk("rst_cathode", 32'(cathode), 32'h7F);
      chk("rst_fs", 32'(frame_sync), 32'(0));
    end

    // Full-brightness scan from reset release.
    for (int i = 0; i < DW; i++) arr[i] = 7'(1 << (i % 7));
    bright = 2'd3;
    enable = 1'b1;
    reset = 1'b1;
    step(1);
    chk("first_fs", 32'(frame_sync), 32'(1));
    step(3);
    chk("pre_lit", 32'(anode), 32'hFF);
    step(1);
    chk("first_lit", 32'(anode), 32'hFE);
    chk("first_cath", 32'(cathode), 32'h7E);
    wait_fs(n);
    scan_frame();
    for (int s = 0; s < DW; s++) chk("lit_full", 32'(lit_cnt[s]), 32'd28);
    wait_fs(n);
    chk("period_next", 32'(n), 32'd1);
    wait_fs(n);
    chk("period", 32'(n), 32'd256);
    wait_anode(8'hF7, "dig3_lit");
    chk("dig3_cath", 32'(cathode), 32'h77);
    wait_anode(8'h7F, "dig7_lit");
    chk("dig7_cath", 32'(cathode), 32'h7E);

    // PWM duty.
    bright = 2'd0;
    wait_fs(n);
    scan_frame();
    chk("lit_b0_d0", 32'(lit_cnt[0]), 32'd7);
    chk("lit_b0_d6", 32'(lit_cnt[6]), 32'd7);
    bright = 2'd1;
    wait_fs(n);
    scan_frame();
    chk("lit_b1_d0", 32'(lit_cnt[0]), 32'd14);
    chk("lit_b1_d5", 32'(lit_cnt[5]), 32'd14);

    // Snapshot isolation.
    bright = 2'd3;
    arr[5] = 7'h3F;
    wait_fs(n);
    wait_anode(8'hFB, "dig2_lit");
    arr[5] = 7'h06;
    wait_anode(8'hDF, "dig5_old");
    chk("snap_old", 32'(cathode), 32'h40);
    wait_fs(n);
    wait_anode(8'hDF, "dig5_new");
    chk("snap_new", 32'(cathode), 32'h79);

    // Enable gating.
    wait_anode(8'hEF, "dig4_lit");
    enable = 1'b0;
    step(1);
    chk("dis_anode", 32'(anode), 32'hFF);
    chk("dis_cath", 32'(cathode), 32'h7F);
    chk("dis_fs", 32'(frame_sync), 32'(0));
    step(3);
    enable = 1'b1;
    step(1);
    chk("reen_fs", 32'(frame_sync), 32'(1));
    step(3);
    chk("reen_blank", 32'(anode), 32'hFF);
    step(1);
    chk("reen_lit", 32'(anode), 32'hFE);

    // Asynchronous reset mid-slot.
    wait_anode(8'hF7, "dig3_pre_rst");
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_anode", 32'(anode), 32'hFF);
    chk("arst_cath", 32'(cathode), 32'h7F);
    chk("arst_fs", 32'(frame_sync), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    step(1);
    chk("arst_fs_rel", 32'(frame_sync), 32'(1));

    // Random frames.
    for (int i = 0; i < 10 * FRAME; i++) begin
      for (int j = 0; j < DW; j++) arr[j] = 7'($urandom);
      bright = 2'($urandom);
      @(negedge clk);
    end

    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexes the per-digit 7-segment patterns produced by the BCD-to-7-segment decoder bank onto a physical common-anode display: one shared cathode bus and one anode line per digit. It sits directly downstream of the decoder bank. Each frame it snapshots the whole digit array and brightness setting, which prevents tearing. It then scans digits 0..DISPLAY_WIDTH-1 using a ghost-suppression blank window and PWM brightness.

## Interface
- DISPLAY_WIDTH, 8: number of digits scanned; must be ≥1.
- REFRESH_DIV, 1024: clock cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be ≥1.
- BRIGHT_WIDTH, 4: width of the brightness input.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- seven_segment_array  input  [DISPLAY_WIDTH-1:0][6:0]  segment patterns, active-high; bit 0 = segment a … bit 6 = segment g; digit 0 is least significant.
- enable  input  1  high enables scanning; low blanks the display and parks the counters.
- brightness  input  BRIGHT_WIDTH  PWM duty code; all ones = full on-time.
- anode  output  DISPLAY_WIDTH  digit select, active-low; at most one bit low at any time.
- cathode  output  7  segment drive, active-low (the inverse of the snapshot pattern).
- frame_sync  output  1  one-cycle pulse marking the start of each frame.

## Operation
- **Scan state:** digit index d (0..DISPLAY_WIDTH-1) and slot counter c (0..REFRESH_DIV-1).
  - c increments every enabled cycle.
  - When c = REFRESH_DIV-1, c wraps to 0 and d advances.
  - After d = DISPLAY_WIDTH-1, d wraps to 0.
- **Snapshot:** on the edge where enable=1 and (d,c)=(0,0), the block latches the full seven_segment_array and brightness into internal registers. Inputs changing mid-frame have no effect until the next frame.
- **On length:** on_len = ((REFRESH_DIV-BLANK_CYCLES) × (snap_brightness+1)) >> BRIGHT_WIDTH, computed at full width with no truncation before the shift.
- **Lit condition:** the block decides "lit" from (d,c):
  - lit = (c ≥ BLANK_CYCLES) and (c − BLANK_CYCLES < on_len).
- **When lit:**
  - anode = all ones except bit d = 0.
  - cathode = ~snapshot[d].
- **When not lit:**
  - anode = all ones.
  - cathode = 7'h7F.
- **frame_sync** asserts for the lit/blank decision made at (d,c)=(0,0) with enable=1.
- **enable low:**
  - d and c are forced to 0 and held.
  - anode = all ones, cathode = 7'h7F, frame_sync = 0.
  - The snapshot registers are retained.
- **Re-enable:** when enable returns high, scanning restarts at (0,0). That cycle takes a new snapshot and produces a frame_sync.
- **Reset values (asynchronous, while reset = 0):** d = 0, c = 0, snapshot = 0, snap_brightness = 0, anode = all ones, cathode = 7'h7F, frame_sync = 0.
- **Reset mid-frame:** state is lost immediately and all outputs go to the blanked reset values. After reset release, scanning restarts at digit 0 with a fresh snapshot.

## Timing
- **Registered outputs:** anode, cathode and frame_sync are registered. The decision for state (d,c) at cycle t appears at the outputs at cycle t+1.
- **Snapshot use:** the snapshot is loaded on the same edge that registers the (0,0) output. The (0,0) output is always blank because BLANK_CYCLES ≥ 1, so no stale data is ever driven.
- **First lit cycle:** with enable held high from reset release, the first lit output for digit 0 appears on cycle BLANK_CYCLES+1 after the first enabled edge.
- **Frame period:** DISPLAY_WIDTH × REFRESH_DIV cycles. frame_sync pulses repeat at exactly this period.
- **Anode transitions:** every transition between digits passes through at least BLANK_CYCLES cycles of all-ones anode.
- **Simultaneous events:** if enable falls at (0,0), the enable-low behaviour takes priority: no snapshot and no frame_sync.

## Test plan
Bench parameters for all scenarios: DISPLAY_WIDTH=8, REFRESH_DIV=32, BLANK_CYCLES=4, BRIGHT_WIDTH=2.

1. **Reset:** hold reset=0 with random inputs → anode=8'hFF, cathode=7'h7F, frame_sync=0. Asynchronously assert reset=0 mid-slot → outputs blank within the same cycle, without waiting for a clock edge.
2. **Full-brightness scan:** enable=1, brightness=3, digit i pattern = 7'h01<<(i%7) → per slot: 4 blank cycles, then 28 cycles with anode bit i low and cathode = ~pattern. Digits proceed 0..7; frame_sync pulses every 256 cycles.
3. **PWM duty:**
   - brightness=0 → 7 lit cycles per slot.
   - brightness=1 → 14 lit cycles per slot.
   - Anode stays all ones for the remainder of each slot.
4. **Snapshot isolation:** change digit 5's pattern from 7'h3F to 7'h06 while digit 2 is lit → cathode for digit 5 is ~7'h3F in the current frame and ~7'h06 from the next frame onward.
5. **Enable gating:** drop enable during digit 4's lit window → blank on the next cycle. Re-raise enable → frame_sync occurs 1 cycle later and digit 0 is lit 5 cycles after the re-raise.
6. **Invariant:** across 10 random frames, popcount(~anode) ≤ 1 on every cycle, and the anode bus is never driven low for two different digits without ≥4 blank cycles between them.
